// File: rtl/rc_pkg.sv
// Shared state encoding, default segment geometry and address helper for the
// reconfiguration sequencer.
package rc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    SETTLE,
    ERR
  } rc_state_e;

  localparam logic [31:0] DEF_SEG_STRIDE      = 32'h20;
  localparam int unsigned DEF_SEG_SIZE        = 16;
  localparam int unsigned DEF_SBT_HEADER_SIZE = 16;

  // Segments are laid out RR-major: all RMs of RR0, then all RMs of RR1, ...
  function automatic logic [31:0] seg_addr(input logic [31:0] rr,
                                           input logic [31:0] rm,
                                           input logic [31:0] num_rm,
                                           input logic [31:0] stride);
    return (rr * num_rm + rm) * stride;
  endfunction

endpackage

// File: rtl/rc_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping around.
module rc_rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any_req
);

  logic [IW-1:0] idx;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'((32'(ptr) + i) % N);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = idx;
      end
    end
  end

endmodule

// File: rtl/rc_sequencer.sv
// Reconfiguration sequencer: loads the requested RM into each mismatched RR via
// icapi, one RR per pass in round-robin order, with isolation and RR reset.
module rc_sequencer
  import rc_pkg::*;
#(
  parameter int unsigned NUM_RR          = 2,
  parameter int unsigned NUM_RM          = 2,
  parameter int unsigned RM_W            = $clog2(NUM_RM),
  parameter logic [31:0] SEG_STRIDE      = DEF_SEG_STRIDE,
  parameter int unsigned SEG_SIZE        = DEF_SEG_SIZE,
  parameter int unsigned SBT_HEADER_SIZE = DEF_SBT_HEADER_SIZE,
  parameter int unsigned TIMEOUT         = 1024
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic [NUM_RR*RM_W-1:0] req_sel,
  output logic                   rc_start,
  output logic                   rc_bop,
  output logic [31:0]            rc_baddr,
  output logic [31:0]            rc_bsize,
  input  logic                   rc_done,
  output logic [NUM_RR-1:0]      isolate,
  output logic [NUM_RR-1:0]      rr_rst,
  output logic [NUM_RR*RM_W-1:0] rm_loaded,
  output logic [NUM_RR-1:0]      loaded_valid,
  output logic                   busy,
  output logic                   err,
  input  logic                   err_clr
);

  localparam int unsigned RR_W = (NUM_RR > 1) ? $clog2(NUM_RR) : 1;
  localparam int unsigned TC_W = $clog2(TIMEOUT + 1);

  rc_state_e       state, state_nxt;
  logic [RR_W-1:0] cur_rr, rr_ptr, grant;
  logic [RM_W-1:0] cur_rm, grant_rm;
  logic [TC_W-1:0] tcnt;
  logic [NUM_RR-1:0] mismatch;
  logic            any_req;
  logic            tmo;

  // Out-of-range requests are never treated as mismatches.
  always_comb begin
    mismatch = '0;
    for (int unsigned i = 0; i < NUM_RR; i++) begin
      if (32'(req_sel[i*RM_W +: RM_W]) < NUM_RM)
        mismatch[i] = !loaded_valid[i] ||
                      (rm_loaded[i*RM_W +: RM_W] != req_sel[i*RM_W +: RM_W]);
    end
  end

  rc_rr_arbiter #(.N(NUM_RR), .IW(RR_W)) u_arb (
    .req     (mismatch),
    .ptr     (rr_ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  assign grant_rm = req_sel[grant*RM_W +: RM_W];
  assign tmo      = (tcnt == TC_W'(TIMEOUT - 1));
  assign rc_bop   = 1'b1;
  assign busy     = (state != IDLE);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (rc_done) state_nxt = SETTLE;
               else if (tmo) state_nxt = ERR;
      SETTLE:  state_nxt = IDLE;
      ERR:     if (err_clr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rc_start     <= 1'b0;
      rc_baddr     <= '0;
      rc_bsize     <= '0;
      isolate      <= '1;
      rr_rst       <= '0;
      rm_loaded    <= '0;
      loaded_valid <= '0;
      err          <= 1'b0;
      rr_ptr       <= '0;
      cur_rr       <= '0;
      cur_rm       <= '0;
      tcnt         <= '0;
    end else begin
      rc_start <= 1'b0;
      rr_rst   <= '0;
      unique case (state)
        IDLE: begin
          isolate <= ~loaded_valid;
          // Outputs are registered one edge early so they are valid throughout START.
          if (any_req) begin
            cur_rr          <= grant;
            cur_rm          <= grant_rm;
            isolate[grant]  <= 1'b1;
            rc_start        <= 1'b1;
            rc_baddr        <= seg_addr(32'(grant), 32'(grant_rm), NUM_RM, SEG_STRIDE);
            rc_bsize        <= 32'(SEG_SIZE + SBT_HEADER_SIZE);
            tcnt            <= '0;
          end
        end
        START: loaded_valid[cur_rr] <= 1'b0;
        WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (rc_done)  rr_rst[cur_rr] <= 1'b1;
          else if (tmo) err <= 1'b1;
        end
        SETTLE: begin
          rm_loaded[cur_rr*RM_W +: RM_W] <= cur_rm;
          loaded_valid[cur_rr]           <= 1'b1;
          rr_ptr <= (cur_rr == RR_W'(NUM_RR - 1)) ? '0 : cur_rr + 1'b1;
        end
        ERR: if (err_clr) err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc_sequencer.sv
// Directed bench for rc_sequencer: table of single-RR reconfigurations plus
// hand sequences for round-robin, timeout/retry, mid-WAIT changes and reset.
module tb_rc_sequencer;

  localparam int unsigned TMO = 16;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [1:0]  req_sel;
  logic        rc_done, err_clr;
  logic        rc_start, rc_bop, busy, err;
  logic [31:0] rc_baddr, rc_bsize;
  logic [1:0]  isolate, rr_rst, rm_loaded, loaded_valid;

  logic [3:0]  req3, rml3;
  logic        start3, bop3, busy3, err3;
  logic [31:0] baddr3, bsize3;
  logic [1:0]  iso3, rrst3, lv3;

  int pass_cnt = 0, total_cnt = 0;
  int start_cnt = 0, start3_cnt = 0, rst_cnt0 = 0, rst_cnt1 = 0;

  always #5 clock = ~clock;

  rc_sequencer #(.NUM_RR(2), .NUM_RM(2), .TIMEOUT(TMO)) dut (
    .clock(clock), .rst_n(rst_n), .req_sel(req_sel), .rc_start(rc_start),
    .rc_bop(rc_bop), .rc_baddr(rc_baddr), .rc_bsize(rc_bsize), .rc_done(rc_done),
    .isolate(isolate), .rr_rst(rr_rst), .rm_loaded(rm_loaded),
    .loaded_valid(loaded_valid), .busy(busy), .err(err), .err_clr(err_clr)
  );

  rc_sequencer #(.NUM_RR(2), .NUM_RM(3), .TIMEOUT(TMO)) dut3 (
    .clock(clock), .rst_n(rst_n), .req_sel(req3), .rc_start(start3),
    .rc_bop(bop3), .rc_baddr(baddr3), .rc_bsize(bsize3), .rc_done(1'b1),
    .isolate(iso3), .rr_rst(rrst3), .rm_loaded(rml3),
    .loaded_valid(lv3), .busy(busy3), .err(err3), .err_clr(1'b0)
  );

  always @(negedge clock) begin
    if (rc_start)  start_cnt++;
    if (start3)    start3_cnt++;
    if (rr_rst[0]) rst_cnt0++;
    if (rr_rst[1]) rst_cnt1++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (actual=hang required=finish)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_rc_start"}, 32'(rc_start), 0);
    check({tag, "_rc_bop"}, 32'(rc_bop), 1);
    check({tag, "_rc_baddr"}, rc_baddr, 0);
    check({tag, "_rc_bsize"}, rc_bsize, 0);
    check({tag, "_isolate"}, 32'(isolate), 'h3);
    check({tag, "_rr_rst"}, 32'(rr_rst), 0);
    check({tag, "_rm_loaded"}, 32'(rm_loaded), 0);
    check({tag, "_loaded_valid"}, 32'(loaded_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic wait_start(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rc_start) break;
      @(negedge clock);
    end
    check("start_seen", 32'(rc_start), 1);
  endtask

  // Returns at the SETTLE-cycle negedge with rc_done already dropped.
  task automatic service(input string tag, input int rr, input logic [31:0] baddr,
                         input logic [1:0] iso_exp, input int delay,
                         input logic [1:0] mid_req);
    bit iso_ok, lv_ok;
    wait_start(40);
    check({tag, "_baddr"}, rc_baddr, baddr);
    check({tag, "_bsize"}, rc_bsize, 32);
    iso_ok = (isolate === iso_exp);
    lv_ok  = 1'b1;
    for (int i = 0; i < delay; i++) begin
      @(negedge clock);
      if (i == 0) req_sel = mid_req;
      iso_ok &= (isolate === iso_exp);
      lv_ok  &= (loaded_valid[rr] === 1'b0) && (busy === 1'b1);
    end
    rc_done = 1'b1;
    @(negedge clock);
    rc_done = 1'b0;
    check({tag, "_rr_rst"}, 32'(rr_rst), 32'(1 << rr));
    iso_ok &= (isolate === iso_exp);
    check({tag, "_isolate_hold"}, 32'(iso_ok), 1);
    check({tag, "_wait_invalid"}, 32'(lv_ok), 1);
    check({tag, "_baddr_held"}, rc_baddr, baddr);
  endtask

  typedef struct {
    logic [1:0]  req;
    int          rr;
    logic [31:0] baddr;
    logic [1:0]  rml;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int s0, r0, r1, cyc;

    vecs[0] = '{req: 2'b11, rr: 1, baddr: 32'h60, rml: 2'b11};
    vecs[1] = '{req: 2'b10, rr: 0, baddr: 32'h00, rml: 2'b10};
    vecs[2] = '{req: 2'b00, rr: 1, baddr: 32'h40, rml: 2'b00};
    vecs[3] = '{req: 2'b01, rr: 0, baddr: 32'h20, rml: 2'b01};

    rst_n = 1'b0; req_sel = 2'b01; rc_done = 1'b0; err_clr = 1'b0; req3 = 4'b1111;
    repeat (3) @(negedge clock);
    reset_checks("reset");
    check("reset_iso3", 32'(iso3), 'h3);

    rst_n = 1'b1;
    @(negedge clock);
    check("start_latency", 32'(rc_start), 1);
    service("init_rr0", 0, 32'h20, 2'b11, 2, 2'b01);
    service("init_rr1", 1, 32'h40, 2'b10, 3, 2'b01);
    repeat (3) @(negedge clock);
    check("init_loaded_valid", 32'(loaded_valid), 'h3);
    check("init_isolate", 32'(isolate), 0);
    check("init_rm_loaded", 32'(rm_loaded), 'h1);
    check("init_busy", 32'(busy), 0);
    check("init_starts", 32'(start_cnt), 2);

    check("rm3_illegal_no_start", 32'(start3_cnt), 0);
    check("rm3_illegal_busy", 32'(busy3), 0);
    req3 = 4'b0111;
    repeat (6) @(negedge clock);
    check("rm3_starts", 32'(start3_cnt), 1);
    check("rm3_baddr", baddr3, 32'h80);
    check("rm3_loaded_valid", 32'(lv3), 'h2);
    check("rm3_rm_loaded", 32'(rml3), 'h4);
    check("rm3_isolate", 32'(iso3), 'h1);

    for (int i = 0; i < 4; i++) begin
      s0 = start_cnt; r0 = rst_cnt0; r1 = rst_cnt1;
      req_sel = vecs[i].req;
      @(negedge clock);
      service($sformatf("vec%0d", i), vecs[i].rr, vecs[i].baddr,
              2'(1 << vecs[i].rr), i + 1, vecs[i].req);
      repeat (3) @(negedge clock);
      check($sformatf("vec%0d_rm_loaded", i), 32'(rm_loaded), 32'(vecs[i].rml));
      check($sformatf("vec%0d_loaded_valid", i), 32'(loaded_valid), 'h3);
      check($sformatf("vec%0d_isolate", i), 32'(isolate), 0);
      check($sformatf("vec%0d_starts", i), 32'(start_cnt - s0), 1);
      check($sformatf("vec%0d_rst_rr0", i), 32'(rst_cnt0 - r0), (vecs[i].rr == 0) ? 1 : 0);
      check($sformatf("vec%0d_rst_rr1", i), 32'(rst_cnt1 - r1), (vecs[i].rr == 1) ? 1 : 0);
    end

    // Both RRs change together with the pointer at RR1.
    s0 = start_cnt;
    req_sel = 2'b10;
    @(negedge clock);
    service("both_rr1", 1, 32'h60, 2'b10, 2, 2'b10);
    service("both_rr0", 0, 32'h00, 2'b01, 2, 2'b10);
    repeat (3) @(negedge clock);
    check("both_starts", 32'(start_cnt - s0), 2);
    check("both_rm_loaded", 32'(rm_loaded), 'h2);

    // Done arrives on the very cycle the timeout would fire.
    req_sel = 2'b00;
    @(negedge clock);
    service("done_edge", 1, 32'h40, 2'b10, TMO, 2'b00);
    @(negedge clock);
    check("done_edge_err", 32'(err), 0);
    check("done_edge_rm_loaded", 32'(rm_loaded), 0);

    // Timeout, ignored rc_done in ERR, then clear and retry.
    s0 = start_cnt; r0 = rst_cnt0;
    req_sel = 2'b01;
    @(negedge clock);
    wait_start(10);
    check("tmo_baddr", rc_baddr, 32'h20);
    cyc = 0;
    for (int i = 0; i < int'(TMO) + 10; i++) begin
      @(negedge clock);
      cyc++;
      if (err) break;
    end
    check("tmo_cycles", 32'(cyc), TMO + 1);
    check("tmo_err", 32'(err), 1);
    check("tmo_isolate", 32'(isolate), 'h1);
    check("tmo_loaded_valid", 32'(loaded_valid), 'h2);
    rc_done = 1'b1;
    @(negedge clock);
    rc_done = 1'b0;
    repeat (3) @(negedge clock);
    check("err_sticky", 32'(err), 1);
    check("err_busy", 32'(busy), 1);
    check("err_no_restart", 32'(start_cnt - s0), 1);
    check("err_no_rr_rst", 32'(rst_cnt0 - r0), 0);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    check("err_cleared", 32'(err), 0);
    service("retry", 0, 32'h20, 2'b01, 3, 2'b01);
    @(negedge clock);
    check("retry_err", 32'(err), 0);
    check("retry_rm_loaded", 32'(rm_loaded), 'h1);
    check("retry_loaded_valid", 32'(loaded_valid), 'h3);

    // Request changes during WAIT: latched RM completes, then a second load.
    req_sel = 2'b00;
    @(negedge clock);
    service("mid_a", 0, 32'h00, 2'b01, 3, 2'b01);
    @(negedge clock);
    check("mid_recorded", 32'(rm_loaded), 0);
    check("mid_recorded_valid", 32'(loaded_valid), 'h3);
    service("mid_b", 0, 32'h20, 2'b01, 2, 2'b01);
    repeat (3) @(negedge clock);
    check("mid_final", 32'(rm_loaded), 'h1);

    // Asynchronous reset in the middle of WAIT.
    req_sel = 2'b11;
    @(negedge clock);
    wait_start(10);
    check("pre_rst_baddr", rc_baddr, 32'h60);
    repeat (2) @(negedge clock);
    #2 rst_n = 1'b0;
    #1 reset_checks("midrst");
    @(negedge clock);
    rst_n = 1'b1;
    service("rst_rr0", 0, 32'h20, 2'b11, 2, 2'b11);
    service("rst_rr1", 1, 32'h60, 2'b10, 2, 2'b11);
    repeat (3) @(negedge clock);
    check("rst_final_valid", 32'(loaded_valid), 'h3);
    check("rst_final_isolate", 32'(isolate), 0);
    check("rst_final_rm_loaded", 32'(rm_loaded), 'h3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
